serial_deserializer: RTL and testbench

Serial-to-parallel receiver, the opposite end of the multiplier's parallel-load/serial-shift register. It samples one bit per enabled clock edge, assembles N-bit words MSB-first or LSB-first, and presents each completed word on a single-entry output buffer with a valid/ready handshake. It also reports partial-word activity and a sticky overrun when a completed word cannot be buffered.

---
 rtl/serial_deserializer.sv | 111 +++++++++++
 tb/tb_serial_deserializer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// serial_deserializer
//   Serial-to-parallel receiver. Samples one bit per enabled edge, assembles
//   N-bit words MSB-first or LSB-first (direction latched on the first bit of
//   each word), and holds each completed word in a single-entry valid/ready
//   output buffer. A completed word that cannot be buffered is dropped and
//   raises a sticky overrun flag.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   clr_i        synchronous clear of partial word and overrun flag
//   ser_en_i     sample ser_in_i on this edge
//   ser_in_i     serial data bit
//   dir_i        1 = MSB-first, 0 = LSB-first (used on the first bit only)
//   out_ready_i  consumer accepts out_data_o this cycle
//   out_data_o   completed word, stable while out_valid_o = 1
//   out_valid_o  out_data_o holds an unconsumed word
//   busy_o       partial word in progress
//   overrun_o    sticky: a completed word was dropped
module serial_deserializer #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         ser_en_i,
  input  logic         ser_in_i,
  input  logic         dir_i,
  input  logic         out_ready_i,
  output logic [N-1:0] out_data_o,
  output logic         out_valid_o,
  output logic         busy_o,
  output logic         overrun_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  logic          dir_eff;
  logic [N-1:0]  sh_shift;
  logic          complete;

  // First bit of a word takes the live direction; later bits use the latch.
  assign dir_eff  = (cnt_q == '0) ? dir_i : dir_q;
  assign sh_shift = dir_eff ? {sh_q[N-2:0], ser_in_i} : {ser_in_i, sh_q[N-1:1]};
  // clr wins over a sample on the same edge, so no word can complete then.
  assign complete = ser_en_i & ~clr_i & (cnt_q == LAST);

  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (clr_i) begin
      sh_d  = '0;
      cnt_d = '0;
      ovr_d = 1'b0;
    end else if (ser_en_i) begin
      sh_d  = sh_shift;
      dir_d = dir_eff;
      cnt_d = complete ? '0 : cnt_q + 1'b1;
    end

    // Holding register: a completing word may replace a word being consumed
    // on the same edge; otherwise a full buffer drops it.
    if (complete) begin
      if (!valid_q || out_ready_i) begin
        data_d  = sh_shift;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (cnt_q != '0);

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (N = 4). Inputs change 1 ns after a
// rising edge; outputs are checked at that same point, away from the edge.
module tb_serial_deserializer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n, clr, ser_en, ser_in, dir, out_ready;
  logic [N-1:0] out_data;
  logic         out_valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  serial_deserializer #(.N(N)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .ser_en_i    (ser_en),
    .ser_in_i    (ser_in),
    .dir_i       (dir),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .busy_o      (busy),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic d);
    ser_en = 1'b1;
    ser_in = b;
    dir    = d;
    step();
    ser_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; ser_en = 1'b0; ser_in = 1'b0;
    dir = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_data",    32'(out_data),  32'h0);
    check("rst_valid",   32'(out_valid), 32'h0);
    check("rst_busy",    32'(busy),      32'h0);
    check("rst_overrun", 32'(overrun),   32'h0);
    rst_n = 1'b1;
    step();
    check("idle_valid",  32'(out_valid), 32'h0);

    // MSB-first 1,0,1,1 -> 4'b1011, valid for exactly one cycle
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1); check("msb_busy1", 32'(busy), 32'h1);
    check("msb_nvalid1", 32'(out_valid), 32'h0);
    send_bit(1'b0, 1'b1); check("msb_busy2", 32'(busy), 32'h1);
    send_bit(1'b1, 1'b1); check("msb_busy3", 32'(busy), 32'h1);
    check("msb_nvalid3", 32'(out_valid), 32'h0);
    send_bit(1'b1, 1'b1);
    check("msb_busy4",  32'(busy),      32'h0);
    check("msb_valid",  32'(out_valid), 32'h1);
    check("msb_data",   32'(out_data),  32'hB);
    step();
    check("msb_consumed", 32'(out_valid), 32'h0);

    // LSB-first with 2-cycle gaps; dir toggled mid-word is ignored
    send_bit(1'b1, 1'b0);
    dir = 1'b1; step(); check("lsb_gap_busy_a", 32'(busy), 32'h1);
    dir = 1'b0; step(); check("lsb_gap_busy_b", 32'(busy), 32'h1);
    send_bit(1'b0, 1'b1);
    step(); step(); check("lsb_gap_busy_c", 32'(busy), 32'h1);
    send_bit(1'b1, 1'b1);
    step(); step(); check("lsb_gap_busy_d", 32'(busy), 32'h1);
    check("lsb_nvalid", 32'(out_valid), 32'h0);
    send_bit(1'b1, 1'b1);
    check("lsb_valid", 32'(out_valid), 32'h1);
    check("lsb_data",  32'(out_data),  32'hD);
    step();
    check("lsb_consumed", 32'(out_valid), 32'h0);

    // Backpressure: A held, 5 dropped, overrun sticky until clr
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
    check("bp_valid_a", 32'(out_valid), 32'h1);
    check("bp_data_a",  32'(out_data),  32'hA);
    check("bp_novr",    32'(overrun),   32'h0);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    check("bp_data_keep", 32'(out_data),  32'hA);
    check("bp_valid",     32'(out_valid), 32'h1);
    check("bp_overrun",   32'(overrun),   32'h1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("bp_drain_valid", 32'(out_valid), 32'h0);
    check("bp_ovr_sticky",  32'(overrun),   32'h1);
    step();
    check("bp_ovr_sticky2", 32'(overrun),   32'h1);
    clr = 1'b1; step(); clr = 1'b0;
    check("bp_clr_ovr", 32'(overrun), 32'h0);

    // Simultaneous consume of 3 and completion of C
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    check("sim_data3", 32'(out_data), 32'h3);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    check("sim_valid", 32'(out_valid), 32'h1);
    check("sim_data",  32'(out_data),  32'hC);
    check("sim_novr",  32'(overrun),   32'h0);
    step();
    check("sim_consumed", 32'(out_valid), 32'h0);

    // clr with a bit on the same edge discards the partial word and the bit
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    clr = 1'b1; send_bit(1'b1, 1'b1); clr = 1'b0;
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_nvalid", 32'(out_valid), 32'h0);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
    check("clr_valid", 32'(out_valid), 32'h1);
    check("clr_data",  32'(out_data),  32'h6);

    // Async reset mid-word (out_data still 6 from the previous word)
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    check("ar_busy_pre", 32'(busy), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_data",    32'(out_data),  32'h0);
    check("ar_valid",   32'(out_valid), 32'h0);
    check("ar_busy",    32'(busy),      32'h0);
    check("ar_overrun", 32'(overrun),   32'h0);
    #2 rst_n = 1'b1;
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    check("ar_nvalid", 32'(out_valid), 32'h0);
    send_bit(1'b1, 1'b1);
    check("ar_post_valid", 32'(out_valid), 32'h1);
    check("ar_post_data",  32'(out_data),  32'hF);
    check("ar_post_novr",  32'(overrun),   32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
